// File: rtl/tlk2711_axi_pkg.sv
// Purpose: shared AXI encodings and FSM state types for the TLK2711 AXI memory slave.
// Contents: burst/response encodings, write/read FSM enums, burst legality helper.
package tlk2711_axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_t;

  // WRAP and the reserved encoding are serviced as INCR but flagged as errors
  function automatic logic burst_bad(input logic [1:0] burst);
    return !((burst == BURST_FIXED) || (burst == BURST_INCR));
  endfunction

endpackage

// File: rtl/tlk2711_axi_mem_ram.sv
// Purpose: simple dual-port RAM, byte write enables, 1-cycle registered read.
// Ports: clk/rst; write port i_we/i_waddr/i_wstrb/i_wdata;
//        read port i_re/i_raddr -> o_rdata (held while i_re is low, cleared by rst).
// Contents survive rst; a same-cycle read and write of one word returns the old data.
module tlk2711_axi_mem_ram #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned MEM_AW     = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_we,
  input  logic [MEM_AW-1:0]       i_waddr,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic                    i_re,
  input  logic [MEM_AW-1:0]       i_raddr,
  output logic [DATA_WIDTH-1:0]   o_rdata
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned DEPTH  = 1 << MEM_AW;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // byte-lane writes
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (i_wstrb[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  // read register only loads on i_re, so it doubles as the stall hold register
  always_ff @(posedge clk) begin
    if (rst)       r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/tlk2711_axi_mem_slave.sv
// Purpose: AXI4 memory responder for the HP0 DMA master; independent read and
//          write engines, one outstanding burst each, backed by a byte-enabled RAM.
// Ports: clk, rst (sync, active-high); AXI4 slave AW/W/B and AR/R channels (s_axi_*).
// Option: define TLK2711_AXI_MEM_PATTERN_EN to return a generated pattern on reads
//         (16-bit lane k = word_index*(DATA_WIDTH/16)+k); writes still update RAM.
module tlk2711_axi_mem_slave
  import tlk2711_axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 40,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned MEM_AW     = 10,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int unsigned STRB_W    = DATA_WIDTH / 8;
  localparam int unsigned OFF       = $clog2(STRB_W);
  localparam int unsigned LAT_W     = (RD_LATENCY > 2) ? $clog2(RD_LATENCY) : 1;
  localparam logic [2:0]  FULL_SIZE = 3'(OFF);

  // ---------------- write engine ----------------
  wr_state_t           r_wstate;
  logic                r_awready, r_wready, r_bvalid;
  logic [1:0]          r_bresp;
  logic [ID_WIDTH-1:0] r_bid;
  logic [MEM_AW-1:0]   r_widx;
  logic [7:0]          r_wlen, r_wbeat;
  logic                r_wfixed, r_werr, r_wover;

  logic              w_aw_hs, w_w_hs, w_b_hs, w_wlen_hit, w_ram_we;
  logic [MEM_AW-1:0] w_aw_idx;

  assign w_aw_hs    = s_axi_awvalid & r_awready;
  assign w_w_hs     = s_axi_wvalid & r_wready;
  assign w_b_hs     = r_bvalid & s_axi_bready;
  assign w_aw_idx   = s_axi_awaddr[MEM_AW+OFF-1:OFF];
  // r_wover marks beats past len+1: still accepted, never written
  assign w_wlen_hit = (r_wbeat == r_wlen) & ~r_wover;
  assign w_ram_we   = w_w_hs & ~r_wover;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_bid     <= '0;
      r_widx    <= '0;
      r_wlen    <= '0;
      r_wbeat   <= '0;
      r_wfixed  <= 1'b0;
      r_werr    <= 1'b0;
      r_wover   <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          r_awready <= 1'b1;
          if (w_aw_hs) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_bid     <= s_axi_awid;
            r_widx    <= w_aw_idx;
            r_wlen    <= s_axi_awlen;
            r_wbeat   <= '0;
            r_wfixed  <= (s_axi_awburst == BURST_FIXED);
            r_werr    <= burst_bad(s_axi_awburst) | (s_axi_awsize != FULL_SIZE);
            r_wover   <= 1'b0;
            r_wstate  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_w_hs) begin
            r_wbeat <= r_wbeat + 8'd1;
            if (!r_wfixed) r_widx <= r_widx + MEM_AW'(1);
            if (w_wlen_hit) r_wover <= 1'b1;
            // burst ends only on wlast; any length disagreement is an error
            if (s_axi_wlast) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= (r_werr | ~w_wlen_hit) ? RESP_SLVERR : RESP_OKAY;
              r_wstate <= W_RESP;
            end else if (w_wlen_hit) begin
              r_werr <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (w_b_hs) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // ---------------- read engine ----------------
  rd_state_t           r_rstate;
  logic                r_arready, r_rvalid, r_rlast, r_rfixed;
  logic [1:0]          r_rresp;
  logic [ID_WIDTH-1:0] r_rid;
  logic [MEM_AW-1:0]   r_ridx;
  logic [7:0]          r_rlen, r_rbeat;
  logic [LAT_W-1:0]    r_rwait;

  logic                  w_ar_hs, w_r_hs, w_ram_re;
  logic [MEM_AW-1:0]     w_ar_idx, w_rnext_idx, w_ram_raddr;
  logic [DATA_WIDTH-1:0] w_ram_q;

  assign w_ar_hs     = s_axi_arvalid & r_arready;
  assign w_r_hs      = r_rvalid & s_axi_rready;
  assign w_ar_idx    = s_axi_araddr[MEM_AW+OFF-1:OFF];
  assign w_rnext_idx = r_rfixed ? r_ridx : r_ridx + MEM_AW'(1);
  // first beat is fetched on the AR handshake, each next beat on the R handshake
  assign w_ram_re    = w_ar_hs | (w_r_hs & ~r_rlast);
  assign w_ram_raddr = w_ar_hs ? w_ar_idx : w_rnext_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rid     <= '0;
      r_rfixed  <= 1'b0;
      r_ridx    <= '0;
      r_rlen    <= '0;
      r_rbeat   <= '0;
      r_rwait   <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          r_arready <= 1'b1;
          if (w_ar_hs) begin
            r_arready <= 1'b0;
            r_rid     <= s_axi_arid;
            r_ridx    <= w_ar_idx;
            r_rlen    <= s_axi_arlen;
            r_rbeat   <= '0;
            r_rfixed  <= (s_axi_arburst == BURST_FIXED);
            r_rlast   <= (s_axi_arlen == 8'd0);
            r_rresp   <= (burst_bad(s_axi_arburst) | (s_axi_arsize != FULL_SIZE)) ?
                         RESP_SLVERR : RESP_OKAY;
            if (RD_LATENCY == 1) begin
              r_rvalid <= 1'b1;
              r_rstate <= R_DATA;
            end else begin
              r_rwait  <= LAT_W'(RD_LATENCY - 2);
              r_rstate <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          if (r_rwait == '0) begin
            r_rvalid <= 1'b1;
            r_rstate <= R_DATA;
          end else begin
            r_rwait <= r_rwait - LAT_W'(1);
          end
        end
        R_DATA: begin
          if (w_r_hs) begin
            if (r_rlast) begin
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
              r_rstate  <= R_IDLE;
            end else begin
              r_rbeat <= r_rbeat + 8'd1;
              r_ridx  <= w_rnext_idx;
              r_rlast <= ((r_rbeat + 8'd1) == r_rlen);
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  tlk2711_axi_mem_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_AW    (MEM_AW)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_ram_we),
    .i_waddr(r_widx),
    .i_wstrb(s_axi_wstrb),
    .i_wdata(s_axi_wdata),
    .i_re   (w_ram_re),
    .i_raddr(w_ram_raddr),
    .o_rdata(w_ram_q)
  );

`ifdef TLK2711_AXI_MEM_PATTERN_EN
  localparam int unsigned LANES = DATA_WIDTH / 16;

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [MEM_AW-1:0] idx);
    logic [DATA_WIDTH-1:0] p;
    logic [31:0]           v;
    p = '0;
    for (int k = 0; k < LANES; k++) begin
      v = 32'(idx) * 32'(LANES) + 32'(k);
      p[16*k +: 16] = v[15:0];
    end
    return p;
  endfunction

  // pattern follows the same fetch/hold timing as the RAM read register
  logic [DATA_WIDTH-1:0] r_pat;
  always_ff @(posedge clk) begin
    if (rst)           r_pat <= '0;
    else if (w_ram_re) r_pat <= pattern(w_ram_raddr);
  end
  assign s_axi_rdata = r_pat;
`else
  assign s_axi_rdata = w_ram_q;
`endif

  // byte-offset and upper address bits are intentionally ignored
  logic w_unused;
  assign w_unused = ^{s_axi_awaddr, s_axi_araddr};

  assign s_axi_awready = r_awready;
  assign s_axi_wready  = r_wready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_bid     = r_bid;
  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rlast   = r_rlast;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rid     = r_rid;

endmodule

// File: tb/tb_tlk2711_axi_mem_slave.sv
// Purpose: scoreboard bench for tlk2711_axi_mem_slave. Drivers push expected
//          B and R responses into queues; monitors pop and compare on handshakes.
module tb_tlk2711_axi_mem_slave;
  import tlk2711_axi_pkg::*;

  localparam int AW  = 40;
  localparam int DW  = 128;
  localparam int IW  = 4;
  localparam int SW  = DW / 8;
  localparam int LAT = 2;

  logic          clk, rst;
  logic [IW-1:0] awid, arid, bid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, arsize;
  logic [1:0]    awburst, arburst, bresp, rresp;
  logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic          arvalid, arready, rvalid, rready, rlast;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;

  tlk2711_axi_mem_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MEM_AW(10), .RD_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
  } rexp_t;
  typedef struct {
    logic [IW-1:0] id;
    logic [1:0]    resp;
  } bexp_t;

  rexp_t rq[$];
  bexp_t bq[$];
  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] mem_m [1024];

  task automatic check(input string name, input logic [DW+7:0] got, input logic [DW+7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got no/unexpected handshake, required a bounded valid response", name);
  endtask

  function automatic logic [DW-1:0] exp_rd(input int idx);
    logic [DW-1:0] w;
`ifdef TLK2711_AXI_MEM_PATTERN_EN
    for (int k = 0; k < DW/16; k++) w[16*k +: 16] = 16'(idx * (DW/16) + k);
`else
    w = mem_m[idx % 1024];
`endif
    return w;
  endfunction

  function automatic int word_of(input logic [AW-1:0] a);
    return int'((a >> 4) & 40'h3FF);
  endfunction

  // R monitor: beat compare on handshake, hold check across stalls
  rexp_t         re;
  logic [DW+7:0] stall_snap;
  bit            stall_prev = 0;
  always @(negedge clk) begin
    if (rvalid && rready) begin
      if (rq.size() == 0) fail("r_unexpected");
      else begin
        re = rq.pop_front();
        check("r_beat", {rid, rdata, rresp, rlast}, {re.id, re.data, re.resp, re.last});
      end
    end
    if (stall_prev && rvalid) check("r_stall_hold", {rid, rdata, rresp, rlast}, stall_snap);
    stall_prev = rvalid && !rready && !rst;
    stall_snap = {rid, rdata, rresp, rlast};
  end

  // B monitor
  bexp_t be;
  always @(negedge clk) begin
    if (bvalid && bready) begin
      if (bq.size() == 0) fail("b_unexpected");
      else begin
        be = bq.pop_front();
        check("b_resp", {bid, bresp}, {be.id, be.resp});
      end
    end
  end

  // which: 0=awready 1=wready 2=arready; returns just after the handshake edge
  task automatic wait_rdy(input int which);
    int n = 0;
    forever begin
      @(negedge clk);
      if ((which == 0 && awready) || (which == 1 && wready) || (which == 2 && arready)) break;
      n++;
      if (n > 200) begin fail("ready_timeout"); break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int nbeats, input logic [DW-1:0] base,
                          input logic [SW-1:0] strb, input logic [1:0] exp_resp);
    int idx = word_of(addr);
    for (int i = 0; i < nbeats; i++) begin
      if (i <= int'(len))
        for (int b = 0; b < SW; b++)
          if (strb[b]) mem_m[idx][b*8 +: 8] = 8'((base + DW'(i)) >> (8*b));
      if (burst != BURST_FIXED) idx = (idx + 1) % 1024;
    end
    bq.push_back('{id, exp_resp});
    awid = id; awaddr = addr; awlen = len; awsize = 3'd4; awburst = burst; awvalid = 1'b1;
    wait_rdy(0);
    awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      wdata = base + DW'(i); wstrb = strb; wlast = (i == nbeats - 1); wvalid = 1'b1;
      wait_rdy(1);
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic issue_read(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] exp_resp);
    int idx = word_of(addr);
    for (int i = 0; i <= int'(len); i++) begin
      rq.push_back('{id, exp_rd(idx), exp_resp, (i == int'(len))});
      idx = (idx + 1) % 1024;
    end
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = BURST_INCR; arvalid = 1'b1;
    wait_rdy(2);
    arvalid = 1'b0;
  endtask

  task automatic do_read(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] exp_resp, input bit toggle,
                         input bit chk_lat);
    int cyc = 0;
    bit seen = 0;
    rready = 1'b1;
    issue_read(id, addr, len, size, exp_resp);
    while (rq.size() > 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (!seen && rvalid) begin
        seen = 1;
        if (chk_lat) check("r_latency", DW'(cyc), DW'(LAT));
      end
      @(posedge clk); #1;
      rready = toggle ? ~rready : 1'b1;
    end
    if (rq.size() != 0) fail("r_drain_timeout");
    rready = 1'b1;
  endtask

  initial begin
    logic any_wready;
    int   n;
    rst = 1'b1;
    {awid, awaddr, awlen, awsize, awburst, awvalid} = '0;
    {wdata, wstrb, wlast, wvalid} = '0;
    {arid, araddr, arlen, arsize, arburst, arvalid} = '0;
    bready = 1'b1; rready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_readys", DW'({awready, wready, arready}), '0);
    check("rst_b", DW'({bvalid, bresp, bid}), '0);
    check("rst_r_ctl", DW'({rvalid, rlast, rresp, rid}), '0);
    check("rst_rdata", DW'(rdata), '0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("readys_after_rst", DW'({awready, arready}), DW'(2'b11));

    // W presented before AW must not be accepted
    wvalid = 1'b1; wdata = '1; wstrb = '1; any_wready = 1'b0;
    repeat (4) begin @(negedge clk); any_wready |= wready; end
    check("w_before_aw", DW'(any_wready), '0);
    @(posedge clk); #1 wvalid = 1'b0;

    // INCR write then read back
    do_write(4'h5, 40'h100, 8'd3, BURST_INCR, 4, '0, '1, RESP_OKAY);
    do_read(4'h3, 40'h100, 8'd3, 3'd4, RESP_OKAY, 0, 1);

    // partial strobe over an all-ones word
    do_write(4'h4, 40'h200, 8'd0, BURST_INCR, 1, '1, '1, RESP_OKAY);
    do_write(4'h4, 40'h200, 8'd0, BURST_INCR, 1, 128'h0123456789ABCDEF_FEDCBA9876543210,
             16'h00FF, RESP_OKAY);
    do_read(4'h6, 40'h200, 8'd0, 3'd4, RESP_OKAY, 0, 0);

    // 16-beat burst read back with rready toggling
    do_write(4'h1, 40'h400, 8'd15, BURST_INCR, 16, 128'h1000, '1, RESP_OKAY);
    do_read(4'hA, 40'h400, 8'd15, 3'd4, RESP_OKAY, 1, 1);

    // early wlast -> SLVERR, then a normal write must still be accepted
    do_write(4'h7, 40'h300, 8'd3, BURST_INCR, 3, 128'h300, '1, RESP_SLVERR);
    do_write(4'h8, 40'h340, 8'd0, BURST_INCR, 1, 128'h340, '1, RESP_OKAY);
    do_read(4'h2, 40'h300, 8'd4, 3'd4, RESP_OKAY, 0, 0);

    // FIXED burst lands every beat on one word; narrow size -> SLVERR
    do_write(4'h9, 40'h600, 8'd1, BURST_FIXED, 2, 128'hA0, '1, RESP_OKAY);
    do_read(4'h9, 40'h600, 8'd0, 3'd4, RESP_OKAY, 0, 0);
    do_read(4'h2, 40'h100, 8'd0, 3'd3, RESP_SLVERR, 0, 0);

`ifdef TLK2711_AXI_MEM_PATTERN_EN
    do_read(4'h0, 40'h20, 8'd1, 3'd4, RESP_OKAY, 0, 0);
`endif

    // reset in the middle of a read burst
    rready = 1'b1;
    issue_read(4'hC, 40'h400, 8'd7, 3'd4, RESP_OKAY);
    n = 0;
    while (rq.size() > 6 && n < 50) begin @(posedge clk); #1; n++; end
    if (rq.size() > 6) fail("mid_read_timeout");
    rready = 1'b0; rst = 1'b1;
    rq.delete();
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_rvalid", DW'(rvalid), '0);
    check("rst_mid_readys", DW'({arready, awready}), '0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("arready_after_mid_rst", DW'(arready), DW'(1'b1));
    do_read(4'hD, 40'h400, 8'd3, 3'd4, RESP_OKAY, 0, 1);

    n = 0;
    while ((bq.size() != 0 || rq.size() != 0) && n < 100) begin @(posedge clk); n++; end
    check("b_queue_empty", DW'(bq.size()), '0);
    check("r_queue_empty", DW'(rq.size()), '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
